zt_stl_lat_fifo: RTL and testbench
==================================

ZT_STL_LAT_FIFO -- requirements
Module: zt_stl_lat_fifo

Interface
REQ-001 Parameter BITDATA, default 8, sets the data width in bits.
REQ-002 Parameter DEPTH, default 4, sets the return-buffer entries and the total credit count; legal when DEPTH>=1 (power of two not required).
REQ-003 Derived width CW = ceil(log2(DEPTH+1)).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 req_vld  input  1  upstream requests issue of one access to the fixed-latency datapath.
REQ-007 req_rdy  output  1  a credit is available; an issue is accepted this cycle.
REQ-008 iss  output  1  issue strobe to the fixed-latency datapath.
REQ-009 rsp_vld  input  1  a response returns from the datapath this cycle.
REQ-010 rsp_dat  input  BITDATA  response data, qualified by rsp_vld.
REQ-011 out_vld  output  1  buffered response available to the consumer.
REQ-012 out_dat  output  BITDATA  head-of-buffer data.
REQ-013 out_rdy  input  1  consumer accepts out_dat this cycle.
REQ-014 credit  output  CW  current free credits.
REQ-015 ovf_err  output  1  sticky flag for a spurious response.

Function
REQ-016 iss SHALL equal req_vld AND req_rdy, combinationally.
REQ-017 req_rdy SHALL equal (credit != 0), decoded from registered state only, with no combinational path from req_vld, rsp_vld or out_rdy.
REQ-018 State SHALL hold: occ (buffer occupancy, 0..DEPTH), infl (issued, not yet returned, 0..DEPTH), credit.
REQ-019 Invariant: credit + occ + infl == DEPTH at every cycle boundary.
REQ-020 infl SHALL update as +1 on iss, -1 on accepted rsp_vld, and remain unchanged when both occur in the same cycle.
REQ-021 Push: accepted rsp_vld SHALL write rsp_dat to mem[wr_ptr] and advance wr_ptr; wr_ptr SHALL wrap from DEPTH-1 to 0.
REQ-022 Pop: out_vld AND out_rdy SHALL advance rd_ptr, with the same wrap rule.
REQ-023 occ SHALL update as +1 on push, -1 on pop, and remain unchanged on simultaneous push and pop.
REQ-024 credit SHALL update as -1 on iss, +1 on pop, and remain unchanged when both occur; a push SHALL NOT change credit.
REQ-025 out_vld SHALL equal (occ != 0); out_dat SHALL equal mem[rd_ptr].
REQ-026 No bypass: a push into an empty buffer in cycle t SHALL give out_vld=1 in cycle t+1, for a minimum rsp_vld-to-out_vld latency of 1 cycle.
REQ-027 While out_vld=1 and out_rdy=0, out_dat SHALL hold stable.
REQ-028 out_dat is don't-care while out_vld=0.
REQ-029 Responses SHALL be delivered in arrival order.
REQ-030 Spurious response: rsp_vld with infl==0 SHALL set ovf_err to 1.
REQ-031 A spurious response SHALL leave mem, pointers and all counters unchanged, and its data SHALL be dropped.
REQ-032 ovf_err SHALL clear only on rst.
REQ-033 Credit exhaustion (credit==0): req_rdy=0, iss=0; a pop in the same cycle restores req_rdy in the next cycle.
REQ-034 With credits correctly held, a push into a full buffer cannot occur; a spurious rsp_vld while occ==DEPTH SHALL follow the spurious-response rule.

Reset
REQ-035 When rst=1 at a rising edge, the next state SHALL be: occ=0, infl=0, credit=DEPTH, wr_ptr=rd_ptr=0, ovf_err=0.
REQ-036 Consequently out_vld=0 and req_rdy=1 the cycle after reset, and iss=0 while req_vld=0.
REQ-037 rst SHALL take priority over simultaneous iss, push and pop.
REQ-038 mem contents SHALL NOT require reset.
REQ-039 Reset mid-operation SHALL discard buffered and in-flight state.
REQ-040 A response arriving after reset for a pre-reset issue SHALL be treated as spurious and SHALL set ovf_err.

Verification (DEPTH=4, BITDATA=8)
REQ-041 Reset then idle -> credit=4, req_rdy=1, out_vld=0, ovf_err=0.
REQ-042 req_vld held high 6 cycles with no rsp_vld -> exactly 4 iss pulses, then credit=0 and req_rdy=0.
REQ-043 4 issues, rsp 0x11,0x22,0x33,0x44 returned 3 cycles later, out_rdy=1 -> out_dat sequence 0x11..0x44, first out_vld one cycle after the first rsp_vld, credit back to 4.
REQ-044 Buffer full with out_rdy=0 for 5 cycles -> out_dat=0x11 held and credit=0; out_rdy=1 while req_vld=1 -> pop and iss in the same cycle after the credit returns, credit stays at or below 1, and wr/rd pointers wrap correctly with DEPTH=3 as well.
REQ-045 rsp_vld=1 with infl=0 -> ovf_err=1, occ unchanged, and the flag remains set until rst.
REQ-046 rst asserted with occ=2, infl=1 -> next cycle out_vld=0, credit=4; the late rsp_vld that follows sets ovf_err.

Source files
------------

// File: rtl/zt_stl_lat_fifo.sv
// zt_stl_lat_fifo: credit-gated return buffer for a fixed-latency datapath.
//
// Every issue into the datapath reserves one return-buffer entry, so the
// responses can always be stored. A credit is given back only when the
// consumer pops the matching entry. Because of this, credit + occ + infl
// always equals DEPTH.
//
// Ports
//   clk      in   sole clock, rising edge
//   rst      in   synchronous, active-high reset
//   req_vld  in   upstream wants to issue one access
//   req_rdy  out  a credit is free; an issue is accepted this cycle
//   iss      out  issue strobe to the datapath (req_vld & req_rdy)
//   rsp_vld  in   response returns from the datapath
//   rsp_dat  in   response data, qualified by rsp_vld
//   out_vld  out  buffered response available
//   out_dat  out  head-of-buffer data
//   out_rdy  in   consumer takes out_dat this cycle
//   credit   out  current free credits
//   ovf_err  out  sticky: a response arrived with nothing in flight
module zt_stl_lat_fifo #(
  parameter int unsigned BITDATA = 8,
  parameter int unsigned DEPTH   = 4,
  localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_vld,
  output logic               req_rdy,
  output logic               iss,
  input  logic               rsp_vld,
  input  logic [BITDATA-1:0] rsp_dat,
  output logic               out_vld,
  output logic [BITDATA-1:0] out_dat,
  input  logic               out_rdy,
  output logic [CW-1:0]      credit,
  output logic               ovf_err
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [BITDATA-1:0] mem_q [DEPTH];

  logic [CW-1:0] occ_q,    occ_d;
  logic [CW-1:0] infl_q,   infl_d;
  logic [CW-1:0] credit_q, credit_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          ovf_err_q, ovf_err_d;

  logic push;
  logic pop;
  logic spurious;

  // Ready comes from registered credit only, so there is no path from any input.
  always_comb begin
    req_rdy = (credit_q != '0);
    iss     = req_vld & req_rdy;
    out_vld = (occ_q != '0);
    out_dat = mem_q[rd_ptr_q];
    credit  = credit_q;
    ovf_err = ovf_err_q;
  end

  // A response with nothing in flight matches no issue: it is flagged and dropped.
  always_comb begin
    spurious = rsp_vld & (infl_q == '0);
    push     = rsp_vld & (infl_q != '0);
    pop      = out_vld & out_rdy;
  end

  always_comb begin
    infl_d = infl_q;
    unique case ({iss, push})
      2'b10:   infl_d = infl_q + CW'(1);
      2'b01:   infl_d = infl_q - CW'(1);
      default: infl_d = infl_q;
    endcase

    occ_d = occ_q;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase

    // A push only moves a reserved slot from in-flight to occupied.
    credit_d = credit_q;
    unique case ({iss, pop})
      2'b10:   credit_d = credit_q - CW'(1);
      2'b01:   credit_d = credit_q + CW'(1);
      default: credit_d = credit_q;
    endcase

    wr_ptr_d = wr_ptr_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end

    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end

    ovf_err_d = ovf_err_q | spurious;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q     <= '0;
      infl_q    <= '0;
      credit_q  <= CW'(DEPTH);
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ovf_err_q <= 1'b0;
    end else begin
      occ_q     <= occ_d;
      infl_q    <= infl_d;
      credit_q  <= credit_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ovf_err_q <= ovf_err_d;
    end
  end

  // Storage is not reset; occupancy alone decides validity. Writes are blocked
  // during reset so that a response in the reset cycle leaves no trace.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= rsp_dat;
    end
  end

endmodule

// File: tb/tb_zt_stl_lat_fifo.sv
module tb_zt_stl_lat_fifo;

  logic       clk;
  logic       rst, req_vld, rsp_vld, out_rdy;
  logic [7:0] rsp_dat;
  logic       req_rdy, iss, out_vld, ovf_err;
  logic [7:0] out_dat;
  logic [2:0] credit;

  logic       rst3, req_vld3, rsp_vld3, out_rdy3;
  logic [7:0] rsp_dat3;
  logic       req_rdy3, iss3, out_vld3, ovf_err3;
  logic [7:0] out_dat3;
  logic [1:0] credit3;

  int checks = 0;
  int errors = 0;

  zt_stl_lat_fifo #(.BITDATA(8), .DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy), .iss(iss),
    .rsp_vld(rsp_vld), .rsp_dat(rsp_dat), .out_vld(out_vld), .out_dat(out_dat),
    .out_rdy(out_rdy), .credit(credit), .ovf_err(ovf_err)
  );

  zt_stl_lat_fifo #(.BITDATA(8), .DEPTH(3)) u_dut3 (
    .clk(clk), .rst(rst3), .req_vld(req_vld3), .req_rdy(req_rdy3), .iss(iss3),
    .rsp_vld(rsp_vld3), .rsp_dat(rsp_dat3), .out_vld(out_vld3), .out_dat(out_dat3),
    .out_rdy(out_rdy3), .credit(credit3), .ovf_err(ovf_err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_vld = 1'b0; rsp_vld = 1'b0; rsp_dat = '0; out_rdy = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (credit !== 3'd4) begin errors++; $display("FAIL reset_credit got %0d want 4", credit); end
    checks++; if (req_rdy !== 1'b1) begin errors++; $display("FAIL reset_req_rdy got %b want 1", req_rdy); end
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld got %b want 0", out_vld); end
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf_err); end
    checks++; if (iss !== 1'b0) begin errors++; $display("FAIL reset_iss got %b want 0", iss); end
  endtask

  task automatic test_credit_exhaust();
    int pulses = 0;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      req_vld = 1'b1;
      #1;
      if (iss === 1'b1) pulses++;
      tick();
    end
    req_vld = 1'b1;
    #1;
    checks++; if (pulses != 4) begin errors++; $display("FAIL exhaust_pulses got %0d want 4", pulses); end
    checks++; if (credit !== 3'd0) begin errors++; $display("FAIL exhaust_credit got %0d want 0", credit); end
    checks++; if (req_rdy !== 1'b0) begin errors++; $display("FAIL exhaust_req_rdy got %b want 0", req_rdy); end
    checks++; if (iss !== 1'b0) begin errors++; $display("FAIL exhaust_iss got %b want 0", iss); end
    req_vld = 1'b0;
  endtask

  task automatic test_in_order();
    logic [7:0] tbl [4];
    tbl = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    for (int c = 0; c < 10; c++) begin
      req_vld = (c < 4);
      rsp_vld = (c >= 3 && c < 7);
      rsp_dat = (c >= 3 && c < 7) ? tbl[c-3] : 8'h00;
      out_rdy = 1'b1;
      #1;
      checks++;
      if (out_vld !== (c >= 4 && c < 8)) begin
        errors++; $display("FAIL order_vld c=%0d got %b want %b", c, out_vld, (c >= 4 && c < 8));
      end
      if (c >= 4 && c < 8) begin
        checks++;
        if (out_dat !== tbl[c-4]) begin
          errors++; $display("FAIL order_dat c=%0d got %h want %h", c, out_dat, tbl[c-4]);
        end
      end
      checks++;
      if (iss !== (c < 4)) begin errors++; $display("FAIL order_iss c=%0d got %b want %b", c, iss, (c < 4)); end
      tick();
    end
    req_vld = 1'b0; rsp_vld = 1'b0;
    #1;
    checks++; if (credit !== 3'd4) begin errors++; $display("FAIL order_credit got %0d want 4", credit); end
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL order_end_vld got %b want 0", out_vld); end
  endtask

  task automatic test_full_hold();
    logic [7:0] tbl [4];
    logic [7:0] e_dat [4];
    logic       e_iss [5];
    logic [2:0] e_cred [5];
    logic       e_vld [5];
    tbl    = '{8'h11, 8'h22, 8'h33, 8'h44};
    e_dat  = '{8'h11, 8'h22, 8'h33, 8'h44};
    e_iss  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    e_cred = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1};
    e_vld  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      req_vld = (c < 4);
      rsp_vld = (c >= 1);
      rsp_dat = (c >= 1) ? tbl[c-1] : 8'h00;
      tick();
    end
    rsp_vld = 1'b0;
    req_vld = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL hold_vld c=%0d got %b want 1", c, out_vld); end
      checks++; if (out_dat !== 8'h11) begin errors++; $display("FAIL hold_dat c=%0d got %h want 11", c, out_dat); end
      checks++; if (credit !== 3'd0) begin errors++; $display("FAIL hold_credit c=%0d got %0d want 0", c, credit); end
      checks++; if (iss !== 1'b0) begin errors++; $display("FAIL hold_iss c=%0d got %b want 0", c, iss); end
      tick();
    end
    out_rdy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (out_vld !== e_vld[c]) begin errors++; $display("FAIL drain_vld c=%0d got %b want %b", c, out_vld, e_vld[c]); end
      if (c < 4) begin
        checks++; if (out_dat !== e_dat[c]) begin errors++; $display("FAIL drain_dat c=%0d got %h want %h", c, out_dat, e_dat[c]); end
      end
      checks++; if (iss !== e_iss[c]) begin errors++; $display("FAIL drain_iss c=%0d got %b want %b", c, iss, e_iss[c]); end
      checks++; if (credit !== e_cred[c]) begin errors++; $display("FAIL drain_credit c=%0d got %0d want %0d", c, credit, e_cred[c]); end
      tick();
    end
    req_vld = 1'b0; out_rdy = 1'b0;
  endtask

  task automatic test_wrap_depth3();
    rst3 = 1'b1; req_vld3 = 1'b0; rsp_vld3 = 1'b0; rsp_dat3 = '0; out_rdy3 = 1'b0;
    tick();
    tick();
    rst3 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      req_vld3 = 1'b1;
      rsp_vld3 = (k >= 1);
      rsp_dat3 = 8'(32'hA0 + k);
      out_rdy3 = 1'b1;
      #1;
      checks++;
      if (credit3 !== ((k == 0) ? 2'd3 : (k == 1) ? 2'd2 : 2'd1)) begin
        errors++; $display("FAIL wrap3_credit k=%0d got %0d", k, credit3);
      end
      if (k >= 2) begin
        checks++; if (out_vld3 !== 1'b1) begin errors++; $display("FAIL wrap3_vld k=%0d got %b want 1", k, out_vld3); end
        checks++;
        if (out_dat3 !== 8'(32'hA0 + k - 1)) begin
          errors++; $display("FAIL wrap3_dat k=%0d got %h want %h", k, out_dat3, 8'(32'hA0 + k - 1));
        end
      end
      tick();
    end
    req_vld3 = 1'b0; rsp_vld3 = 1'b0; out_rdy3 = 1'b0;
    #1;
    checks++; if (ovf_err3 !== 1'b0) begin errors++; $display("FAIL wrap3_ovf got %b want 0", ovf_err3); end
  endtask

  task automatic test_spurious();
    logic [7:0] tbl [4];
    tbl = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    do_reset();
    rsp_vld = 1'b1; rsp_dat = 8'h5A;
    tick();
    rsp_vld = 1'b0;
    #1;
    checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL spur_ovf got %b want 1", ovf_err); end
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL spur_occ got %b want 0", out_vld); end
    checks++; if (credit !== 3'd4) begin errors++; $display("FAIL spur_credit got %0d want 4", credit); end
    req_vld = 1'b1;
    tick();
    req_vld = 1'b0; rsp_vld = 1'b1; rsp_dat = 8'h77;
    tick();
    rsp_vld = 1'b0;
    #1;
    checks++; if (out_dat !== 8'h77) begin errors++; $display("FAIL spur_real_dat got %h want 77", out_dat); end
    checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL spur_sticky got %b want 1", ovf_err); end
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      req_vld = (c < 4);
      rsp_vld = (c >= 1);
      rsp_dat = (c >= 1) ? tbl[c-1] : 8'h00;
      tick();
    end
    req_vld = 1'b0; rsp_vld = 1'b1; rsp_dat = 8'hEE;
    tick();
    rsp_vld = 1'b0;
    #1;
    checks++; if (credit !== 3'd0) begin errors++; $display("FAIL spur_full_credit got %0d want 0", credit); end
    out_rdy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (out_dat !== tbl[c]) begin errors++; $display("FAIL spur_full_dat c=%0d got %h want %h", c, out_dat, tbl[c]); end
      tick();
    end
    out_rdy = 1'b0;
    #1;
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL spur_full_vld got %b want 0", out_vld); end
    checks++; if (credit !== 3'd4) begin errors++; $display("FAIL spur_full_end_credit got %0d want 4", credit); end
    checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL spur_still_set got %b want 1", ovf_err); end
    do_reset();
    #1;
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL spur_rst_clear got %b want 0", ovf_err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      req_vld = 1'b1;
      rsp_vld = (c >= 1);
      rsp_dat = (c == 1) ? 8'h61 : 8'h62;
      tick();
    end
    req_vld = 1'b0; rsp_vld = 1'b0;
    #1;
    checks++; if (out_dat !== 8'h61) begin errors++; $display("FAIL mid_pre_dat got %h want 61", out_dat); end
    checks++; if (credit !== 3'd1) begin errors++; $display("FAIL mid_pre_credit got %0d want 1", credit); end
    rst = 1'b1; req_vld = 1'b1; rsp_vld = 1'b1; rsp_dat = 8'h99; out_rdy = 1'b1;
    tick();
    rst = 1'b0; req_vld = 1'b0; rsp_vld = 1'b0; out_rdy = 1'b0;
    #1;
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL mid_vld got %b want 0", out_vld); end
    checks++; if (credit !== 3'd4) begin errors++; $display("FAIL mid_credit got %0d want 4", credit); end
    checks++; if (req_rdy !== 1'b1) begin errors++; $display("FAIL mid_req_rdy got %b want 1", req_rdy); end
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL mid_ovf got %b want 0", ovf_err); end
    rsp_vld = 1'b1; rsp_dat = 8'h63;
    tick();
    rsp_vld = 1'b0;
    #1;
    checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL mid_late_ovf got %b want 1", ovf_err); end
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL mid_late_vld got %b want 0", out_vld); end
    checks++; if (credit !== 3'd4) begin errors++; $display("FAIL mid_late_credit got %0d want 4", credit); end
  endtask

  initial begin
    rst = 1'b1; req_vld = 1'b0; rsp_vld = 1'b0; rsp_dat = '0; out_rdy = 1'b0;
    rst3 = 1'b1; req_vld3 = 1'b0; rsp_vld3 = 1'b0; rsp_dat3 = '0; out_rdy3 = 1'b0;
    test_reset();
    test_credit_exhaust();
    test_in_order();
    test_full_hold();
    test_wrap_depth3();
    test_spurious();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
